// File: rtl/prbs7_lane_checker.sv
// Self-synchronizing PRBS7 (x^7+x^6+1) checker for one deserialized RX lane; PRBS7_CHK_INJECT_EN adds INJ_ERR self-test.
// Latency: compare result and all outputs update 1 clock after the accepting edge.
// Backpressure: none; one word per clock is accepted whenever RX_VALID and ALGN_DONE are high.
module prbs7_lane_checker #(
    parameter int DW          = 8,
    parameter int LOCK_CNT    = 16,
    parameter int UNLOCK_THR  = 4,
    parameter int ACQ_TIMEOUT = 1024,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [DW-1:0]    RX_DATA,
    input  logic             RX_VALID,
    input  logic             ALGN_DONE,
    input  logic             CLR_ERR,
`ifdef PRBS7_CHK_INJECT_EN
    input  logic             INJ_ERR,
`endif
    output logic             PRBS_LOCK,
    output logic             PRBS_ERR,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic             ACQ_FAIL
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(ACQ_TIMEOUT + 1);
    localparam int BW = $clog2(UNLOCK_THR + 1);

    localparam logic [GW-1:0]    GOOD_LAST = GW'(LOCK_CNT - 1);
    localparam logic [GW-1:0]    GOOD_ONE  = GW'(1);
    localparam logic [WW-1:0]    WORD_LAST = WW'(ACQ_TIMEOUT - 1);
    localparam logic [WW-1:0]    WORD_ONE  = WW'(1);
    localparam logic [BW-1:0]    BAD_LAST  = BW'(UNLOCK_THR - 1);
    localparam logic [BW-1:0]    BAD_ONE   = BW'(1);
    localparam logic [CNT_W-1:0] ERR_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_SEED, ST_ACQUIRE, ST_LOCKED} state_t;

    state_t        state;
    logic [DW-1:0] rx_in;
    logic [DW-1:0] rx_q;
    logic          rx_vld_q;
    logic          clr_q;
    logic [6:0]    hist;
    logic [GW-1:0] good_cnt;
    logic [WW-1:0] word_cnt;
    logic [BW-1:0] bad_run;
    logic          word_good;
    logic          err_hit;
    logic          acq_hit;

`ifdef PRBS7_CHK_INJECT_EN
    always_comb begin
        rx_in         = RX_DATA;
        rx_in[DW-1]   = RX_DATA[DW-1] ^ INJ_ERR;
    end
`else
    assign rx_in = RX_DATA;
`endif

    // Predict each bit from the history, then shift in the received bit so one
    // flipped bit only disturbs the bits that depend on it.
    function automatic logic check_word(input logic [6:0] h_in, input logic [DW-1:0] w);
        logic [6:0] h;
        logic       ok;
        h  = h_in;
        ok = 1'b1;
        for (int i = DW - 1; i >= 0; i--) begin
            if (w[i] != (h[6] ^ h[5]))
                ok = 1'b0;
            h = {h[5:0], w[i]};
        end
        return ok && (h != 7'd0);
    endfunction

    assign word_good = check_word(hist, rx_q);
    assign err_hit   = ALGN_DONE && rx_vld_q && (state == ST_LOCKED) && !word_good;
    assign acq_hit   = ALGN_DONE && rx_vld_q && (state == ST_ACQUIRE) && (word_cnt == WORD_LAST);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state     <= ST_IDLE;
            rx_q      <= '0;
            rx_vld_q  <= 1'b0;
            clr_q     <= 1'b0;
            hist      <= '0;
            good_cnt  <= '0;
            word_cnt  <= '0;
            bad_run   <= '0;
            PRBS_LOCK <= 1'b0;
        end else begin
            clr_q    <= CLR_ERR;
            rx_vld_q <= RX_VALID && ALGN_DONE;
            if (RX_VALID && ALGN_DONE)
                rx_q <= rx_in;

            if (!ALGN_DONE) begin
                state     <= ST_IDLE;
                PRBS_LOCK <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_SEED;
                    ST_SEED: begin
                        if (rx_vld_q) begin
                            hist     <= rx_q[6:0];
                            good_cnt <= '0;
                            word_cnt <= '0;
                            state    <= ST_ACQUIRE;
                        end
                    end
                    ST_ACQUIRE: begin
                        if (rx_vld_q) begin
                            hist <= rx_q[6:0];
                            if (!word_good) begin
                                good_cnt <= '0;
                            end else if (good_cnt == GOOD_LAST) begin
                                good_cnt  <= '0;
                                bad_run   <= '0;
                                state     <= ST_LOCKED;
                                PRBS_LOCK <= 1'b1;
                            end else begin
                                good_cnt <= good_cnt + GOOD_ONE;
                            end
                            word_cnt <= (word_cnt == WORD_LAST) ? '0 : word_cnt + WORD_ONE;
                        end
                    end
                    ST_LOCKED: begin
                        if (rx_vld_q) begin
                            hist <= rx_q[6:0];
                            if (word_good) begin
                                bad_run <= '0;
                            end else if (bad_run == BAD_LAST) begin
                                bad_run   <= '0;
                                good_cnt  <= '0;
                                word_cnt  <= '0;
                                state     <= ST_ACQUIRE;
                                PRBS_LOCK <= 1'b0;
                            end else begin
                                bad_run <= bad_run + BAD_ONE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Clear travels with the word it arrived with, so it beats that word's error.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            ERR_CNT  <= '0;
            PRBS_ERR <= 1'b0;
            ACQ_FAIL <= 1'b0;
        end else if (clr_q) begin
            ERR_CNT  <= '0;
            PRBS_ERR <= 1'b0;
            ACQ_FAIL <= 1'b0;
        end else begin
            if (err_hit) begin
                PRBS_ERR <= 1'b1;
                if (ERR_CNT != ERR_MAX)
                    ERR_CNT <= ERR_CNT + CNT_ONE;
            end
            if (acq_hit)
                ACQ_FAIL <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prbs7_lane_checker.sv
// Randomized scoreboard bench for prbs7_lane_checker: a cycle model predicts outputs, a monitor compares them.
`timescale 1ns/1ps
module tb_prbs7_lane_checker;
    localparam int DW = 8;
    localparam int LOCK_CNT = 16;
    localparam int UNLOCK_THR = 4;
    localparam int ACQ_TIMEOUT = 1024;
    localparam int M_IDLE = 0, M_SEED = 1, M_ACQ = 2, M_LOCK = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, rx_vld, algn, clr;
    logic [DW-1:0] rx_dat;
    logic          lock, perr, afail, lock2, perr2, afail2;
    logic [15:0]   cnt;
    logic [1:0]    cnt2;
`ifdef PRBS7_CHK_INJECT_EN
    logic          inj = 1'b0;
`endif

    prbs7_lane_checker #(.DW(DW), .CNT_W(16)) u_dut (
        .CLK(clk), .RESETN(rst_n), .RX_DATA(rx_dat), .RX_VALID(rx_vld),
        .ALGN_DONE(algn), .CLR_ERR(clr),
`ifdef PRBS7_CHK_INJECT_EN
        .INJ_ERR(inj),
`endif
        .PRBS_LOCK(lock), .PRBS_ERR(perr), .ERR_CNT(cnt), .ACQ_FAIL(afail));

    prbs7_lane_checker #(.DW(DW), .CNT_W(2)) u_dut_sat (
        .CLK(clk), .RESETN(rst_n), .RX_DATA(rx_dat), .RX_VALID(rx_vld),
        .ALGN_DONE(algn), .CLR_ERR(clr),
`ifdef PRBS7_CHK_INJECT_EN
        .INJ_ERR(inj),
`endif
        .PRBS_LOCK(lock2), .PRBS_ERR(perr2), .ERR_CNT(cnt2), .ACQ_FAIL(afail2));

    typedef struct packed {
        logic        lock;
        logic        perr;
        logic [15:0] cnt;
        logic        afail;
        logic [1:0]  cnt2;
    } obs_t;

    obs_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    int            m_state, m_good, m_words, m_bad, m_errs;
    bit            m_lock, m_perr, m_fail;
    bit            m_pend_vld, m_pend_clr;
    logic [DW-1:0] m_pend;
    bit            hq[$];   // last 7 received bits, index 0 oldest
    bit            gq[$];   // stimulus generator history

    function automatic int sat(input int n, input int m);
        return (n > m) ? m : n;
    endfunction

    function automatic bit is_good(input logic [DW-1:0] w);
        bit q[$];
        bit ok, any;
        q  = hq;
        ok = 1'b1;
        any = 1'b0;
        for (int i = DW - 1; i >= 0; i--) begin
            if (w[i] !== (q[0] ^ q[1])) ok = 1'b0;
            q.push_back(w[i]);
            void'(q.pop_front());
        end
        foreach (q[j]) if (q[j]) any = 1'b1;
        return ok && any;
    endfunction

    task automatic load_hist(input logic [DW-1:0] w);
        hq.delete();
        for (int i = 6; i >= 0; i--) hq.push_back(w[i]);
    endtask

    task automatic model_reset();
        m_state = M_IDLE; m_good = 0; m_words = 0; m_bad = 0; m_errs = 0;
        m_lock = 0; m_perr = 0; m_fail = 0;
        m_pend_vld = 0; m_pend_clr = 0; m_pend = '0;
        hq.delete();
        for (int i = 0; i < 7; i++) hq.push_back(1'b0);
    endtask

    function automatic obs_t model_obs();
        obs_t e;
        e.lock  = m_lock;
        e.perr  = m_perr;
        e.cnt   = 16'(sat(m_errs, 65535));
        e.afail = m_fail;
        e.cnt2  = 2'(sat(m_errs, 3));
        return e;
    endfunction

    // Advance the model by one active edge using the inputs sampled at that edge.
    task automatic model_step();
        bit g;
        bit bad_hit = 1'b0;
        bit tmo = 1'b0;
        if (!algn) begin
            m_state = M_IDLE;
            m_lock  = 1'b0;
        end else if (m_state == M_IDLE) begin
            m_state = M_SEED;
        end else if (m_pend_vld) begin
            g = is_good(m_pend);
            if (m_state == M_SEED) begin
                m_good = 0; m_words = 0; m_state = M_ACQ;
            end else if (m_state == M_ACQ) begin
                m_good = g ? m_good + 1 : 0;
                if (m_good == LOCK_CNT) begin
                    m_state = M_LOCK; m_lock = 1'b1; m_good = 0; m_bad = 0;
                end
                m_words++;
                if (m_words == ACQ_TIMEOUT) begin tmo = 1'b1; m_words = 0; end
            end else begin
                if (g) m_bad = 0;
                else begin
                    bad_hit = 1'b1;
                    m_bad++;
                    if (m_bad == UNLOCK_THR) begin
                        m_state = M_ACQ; m_lock = 1'b0; m_good = 0; m_words = 0; m_bad = 0;
                    end
                end
            end
            load_hist(m_pend);
        end
        if (m_pend_clr) begin
            m_errs = 0; m_perr = 1'b0; m_fail = 1'b0;
        end else begin
            if (bad_hit) begin m_errs++; m_perr = 1'b1; end
            if (tmo) m_fail = 1'b1;
        end
        m_pend_vld = algn && rx_vld;
        if (m_pend_vld) m_pend = rx_dat;
        m_pend_clr = clr;
    endtask

    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit c, input bit a);
        rx_vld = v; rx_dat = d; clr = c; algn = a;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        sb_q.push_back(model_obs());
        #1;
    endtask

    function automatic logic [DW-1:0] gen_word();
        logic [DW-1:0] w;
        bit b;
        for (int i = DW - 1; i >= 0; i--) begin
            b = gq[0] ^ gq[1];
            w[i] = b;
            gq.push_back(b);
            void'(gq.pop_front());
        end
        return w;
    endfunction

    task automatic send(input bit flip, input bit c);
        logic [DW-1:0] w;
        w = gen_word();
        if (flip) w[DW-1] = ~w[DW-1];
        cycle(1'b1, w, c, 1'b1);
    endtask

    task automatic run_clean(input int n, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap_pct) cycle(1'b0, DW'($urandom), 1'b0, 1'b1);
            send(1'b0, 1'b0);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a = {lock, perr, cnt, afail, cnt2};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL scoreboard t=%0t: got lock=%b err=%b cnt=%0d fail=%b cnt2=%0d, expected lock=%b err=%b cnt=%0d fail=%b cnt2=%0d",
                             $time, a.lock, a.perr, a.cnt, a.afail, a.cnt2,
                             e.lock, e.perr, e.cnt, e.afail, e.cnt2);
                end
            end
        end
    end

    initial begin : stim
        logic [6:0] seed;
        rst_n = 1'b0; rx_vld = 1'b0; rx_dat = '0; clr = 1'b0; algn = 1'b0;
        model_reset();
        seed = 7'($urandom_range(1, 127));
        for (int i = 6; i >= 0; i--) gq.push_back(seed[i]);

        repeat (3) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
        settle();
        chk("reset_lock", lock, 0);
        chk("reset_cnt", cnt, 0);
        rst_n = 1'b1;
        repeat (5) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);

        // Lock latency: first word seeds, 16 good words follow.
        for (int i = 0; i < 17; i++) send(1'b0, 1'b0);
        settle();
        chk("lock_not_early", lock, 0);
        send(1'b0, 1'b0);
        settle();
        chk("lock_after_17", lock, 1);

        run_clean(10000, 15);
        settle();
        chk("clean_err_cnt", cnt, 0);
        chk("clean_lock", lock, 1);

        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        settle();
        chk("single_err_cnt", cnt, 1);
        chk("single_prbs_err", perr, 1);
        chk("single_lock_held", lock, 1);

        send(1'b0, 1'b1);
        repeat (4) send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        settle();
        chk("burst_err_cnt", cnt, 4);
        chk("burst_unlock", lock, 0);
        chk("burst_sat_cnt", cnt2, 3);

        run_clean(20, 0);
        send(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 1'b0);
            send(1'b0, 1'b0);
        end
        settle();
        chk("spaced_err_cnt", cnt, 5);
        chk("spaced_sat_cnt", cnt2, 3);
        chk("spaced_lock", lock, 1);

        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        settle();
        chk("clr_wins_cnt", cnt, 0);
        chk("clr_wins_err", perr, 0);
        chk("clr_keeps_lock", lock, 1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
        settle();
        chk("algn_drop_unlock", lock, 0);
        repeat (3) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
        run_clean(18, 0);
        settle();
        chk("relock_after_algn", lock, 1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 10) cycle(1'b0, DW'($urandom), $urandom_range(99) < 1, 1'b1);
            else send($urandom_range(99) < 3, $urandom_range(99) < 1);
        end

        // All-zero stream never locks and times out acquisition.
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < ACQ_TIMEOUT + 1; i++) cycle(1'b1, '0, 1'b0, 1'b1);
        settle();
        chk("acq_fail_not_early", afail, 0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        settle();
        chk("acq_fail_set", afail, 1);
        chk("zeros_no_lock", lock, 0);

        cycle(1'b0, '0, 1'b0, 1'b0);
        run_clean(20, 0);
        settle();
        chk("pre_reset_lock", lock, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_lock", lock, 0);
        chk("async_rst_err", perr, 0);
        chk("async_rst_cnt", cnt, 0);
        chk("async_rst_fail", afail, 0);
        repeat (2) cycle(1'b1, DW'($urandom), 1'b0, 1'b1);
        rst_n = 1'b1;
        repeat (8) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
        settle();
        chk("idle_after_rst", lock, 0);
        run_clean(18, 0);
        settle();
        chk("relock_after_rst", lock, 1);

        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
